// File: rtl/bg_scroll_pkg.sv
// Shared types and helpers for the scrolling background address generator.
// Direction bit indices, coordinate type and modular offset arithmetic.
package bg_scroll_pkg;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_LEFT  = 0;

  typedef logic [9:0] coord_t;

  // Add with a single wrap; inputs assumed already in 0..m-1 and s < m.
  function automatic coord_t wrap_add(coord_t v, coord_t s, coord_t m);
    logic [10:0] sum;
    sum = {1'b0, v} + {1'b0, s};
    if (sum >= {1'b0, m})
      return coord_t'(sum - {1'b0, m});
    return coord_t'(sum);
  endfunction

  // Subtract with a single wrap; inputs assumed already in 0..m-1 and s < m.
  function automatic coord_t wrap_sub(coord_t v, coord_t s, coord_t m);
    logic [10:0] tmp;
    if (v < s) begin
      tmp = {1'b0, v} + {1'b0, m} - {1'b0, s};
      return coord_t'(tmp);
    end
    return v - s;
  endfunction

endpackage

// File: rtl/bg_frame_sync.sv
// Frame strobe synchroniser and rising-edge detector.
// A level already high when reset releases is ignored until it drops.
module bg_frame_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync0;
  logic sync1;
  logic sync2;
  logic fill0;
  logic fill1;
  logic armed;

  // Two-stage sync, history bit, and arming once a real low is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      fill0      <= 1'b0;
      fill1      <= 1'b0;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      sync0      <= frame_clk;
      sync1      <= sync0;
      sync2      <= sync1;
      fill0      <= 1'b1;
      fill1      <= fill0;
      armed      <= armed | (fill1 & ~sync1);
      frame_tick <= armed & sync1 & ~sync2;
    end
  end

endmodule

// File: rtl/bg_scroll_addr_gen.sv
// Scrolling background address generator: per-frame offsets, 2-stage ROM address.
// Optional speed ramp when BG_SCROLL_ACCEL_EN is defined.
module bg_scroll_addr_gen
  import bg_scroll_pkg::*;
#(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int MAP_W        = 960,
  parameter int MAP_H        = 720,
  parameter int ADDR_W       = 20,
  parameter int STEP         = 1,
  parameter int STEP_MAX     = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              frame_clk,
  input  logic [3:0]        direction,
  input  logic              collided,
  input  logic              recenter,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  output logic [ADDR_W-1:0] rom_address,
  output logic              pix_blank,
  output logic [9:0]        x_offset,
  output logic [9:0]        y_offset,
  output logic              frame_tick
);

  localparam coord_t MW = coord_t'(MAP_W);
  localparam coord_t MH = coord_t'(MAP_H);

  logic up;
  logic down;
  logic right;
  logic left;

  assign up    = direction[DIR_UP];
  assign down  = direction[DIR_DOWN];
  assign right = direction[DIR_RIGHT];
  assign left  = direction[DIR_LEFT];

  bg_frame_sync u_sync (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  coord_t speed;

`ifdef BG_SCROLL_ACCEL_EN
  localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  logic [CNT_W-1:0] accel_cnt;
  logic             moving;

  assign moving = ((up ^ down) | (right ^ left)) & ~collided;

  // Ramp speed while a real move is held; any stop or recenter drops it.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      speed     <= coord_t'(STEP);
      accel_cnt <= '0;
    end else if (frame_tick) begin
      if (recenter || !moving) begin
        speed     <= coord_t'(STEP);
        accel_cnt <= '0;
      end else if (accel_cnt == CNT_W'(ACCEL_FRAMES - 1)) begin
        accel_cnt <= '0;
        if (speed < coord_t'(STEP_MAX))
          speed <= speed + coord_t'(1);
      end else begin
        accel_cnt <= accel_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign speed = coord_t'(STEP);
`endif

  coord_t x_next;
  coord_t y_next;

  // Next offsets: recenter beats freeze, freeze beats movement.
  always_comb begin
    x_next = x_offset;
    y_next = y_offset;
    if (recenter) begin
      x_next = '0;
      y_next = '0;
    end else if (!collided) begin
      if (up && !down)
        y_next = wrap_sub(y_offset, speed, MH);
      else if (down && !up)
        y_next = wrap_add(y_offset, speed, MH);
      if (right && !left)
        x_next = wrap_add(x_offset, speed, MW);
      else if (left && !right)
        x_next = wrap_sub(x_offset, speed, MW);
    end
  end

  // Offsets only move on the frame tick.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_offset <= '0;
      y_offset <= '0;
    end else if (frame_tick) begin
      x_offset <= x_next;
      y_offset <= y_next;
    end
  end

  logic [10:0] sum_x;
  logic [10:0] sum_y;
  coord_t      px_n;
  coord_t      py_n;

  // Map-space pixel position with one wrap per axis.
  always_comb begin
    sum_x = {1'b0, DrawX} + {1'b0, x_offset};
    sum_y = {1'b0, DrawY} + {1'b0, y_offset};
    px_n  = coord_t'(sum_x);
    py_n  = coord_t'(sum_y);
    if (sum_x >= 11'(MAP_W))
      px_n = coord_t'(sum_x - 11'(MAP_W));
    if (sum_y >= 11'(MAP_H))
      py_n = coord_t'(sum_y - 11'(MAP_H));
  end

  coord_t s1_px;
  coord_t s1_py;
  logic   s1_blank;

  // Stage 1: register wrapped coordinates and blank.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_px    <= '0;
      s1_py    <= '0;
      s1_blank <= 1'b0;
    end else begin
      s1_px    <= px_n;
      s1_py    <= py_n;
      s1_blank <= blank;
    end
  end

  logic [ADDR_W-1:0] lin_addr;

  assign lin_addr = ADDR_W'(s1_py) * ADDR_W'(MAP_W) + ADDR_W'(s1_px);

  // Stage 2: linear ROM address, zeroed outside active display.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      pix_blank   <= 1'b0;
    end else begin
      rom_address <= s1_blank ? lin_addr : '0;
      pix_blank   <= s1_blank;
    end
  end

endmodule

// File: doc/bg_scroll_addr_gen.md
Name: bg_scroll_addr_gen

Overview:
Parametrised scrolling-background address generator for the Bosconian video path. Keeps per-axis scroll offsets that wrap over the full background map, not the screen. Offsets update once per frame from a one-hot direction input, with diagonal motion and collision freeze. Emits a pipelined ROM address with a matching delayed blank, so the background ROM/palette stage lines up with DrawX/DrawY.

Parameters:
SCREEN_W, 640, visible width in pixels; must be <= MAP_W
SCREEN_H, 480, visible height; must be <= MAP_H
MAP_W, 960, background map width in pixels
MAP_H, 720, background map height in pixels
ADDR_W, 20, ROM address width; MAP_W*MAP_H <= 2**ADDR_W
STEP, 1, pixels moved per frame per active axis; 1 <= STEP < min(MAP_W, MAP_H)
STEP_MAX, 4, top speed when accel is enabled; STEP <= STEP_MAX < min(MAP_W, MAP_H)
ACCEL_FRAMES, 8, frames per speed increment when accel is enabled

Ports:
vga_clk  in  1  pixel clock, the only clock
reset_n  in  1  asynchronous active-low reset
frame_clk  in  1  frame strobe; synchronised with a 2-FF chain and rising-edge detected inside the block
direction  in  4  one-hot-ish scroll request: [3] up, [2] down, [1] right, [0] left
collided  in  1  freeze scrolling while high
recenter  in  1  zero both offsets at the next frame edge
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
blank  in  1  1 = active display
rom_address  out  ADDR_W  background ROM address, 2 cycles after DrawX/DrawY
pix_blank  out  1  blank delayed by 2 cycles, aligned with rom_address
x_offset  out  10  current x scroll, range 0..MAP_W-1
y_offset  out  10  current y scroll, range 0..MAP_H-1
frame_tick  out  1  one-cycle pulse on each detected frame edge

Behaviour:
- Reset: all outputs 0, sync FFs 0, speed = STEP, accel counter 0.
- frame_tick: high for exactly one vga_clk, 3 cycles after frame_clk rises (2 sync FFs + edge register).
- Offsets change only on a cycle where frame_tick is high. Priority on that cycle:
  - recenter: both offsets set to 0.
  - else collided: both offsets hold.
  - else apply moves: up subtracts speed from y; down adds to y; right adds to x; left subtracts from x.
- up+down together means no y change; left+right together means no x change. Diagonals move both axes in the same frame.
- direction = 0 holds the offsets. It does not reset them, unlike the prior generation.
- Offset wrap:
  - add: if off+speed >= MAP, result is off+speed-MAP.
  - subtract: if off < speed, result is off+MAP-speed.
  - Offsets never leave 0..MAP-1.
- Address pipeline (latency 2, fully pipelined, one pixel per cycle):
  - S1 registers px = DrawX+x_offset, subtracting MAP_W once if >= MAP_W; py the same for Y/MAP_H; registers blank.
  - S2 registers rom_address = py*MAP_W + px, truncated to ADDR_W; registers pix_blank.
  - When the S1 blank is 0, rom_address is forced to 0.
- An offset update mid-frame takes effect on the next S1 sample. No tearing guarantee beyond this, because frame_clk is expected during vertical blank.
- Reset asserted mid-frame clears everything immediately. After release, the first frame_tick needs a fresh frame_clk rise; a level that is already high does not count.

Optional Feature:
BG_SCROLL_ACCEL_EN:
- Defined:
  - While any non-cancelling direction is held and collided is low, the accel counter counts frame_ticks.
  - Every ACCEL_FRAMES ticks, speed increments by 1, saturating at STEP_MAX.
  - direction = 0, collided, or recenter returns speed to STEP and clears the counter at that frame_tick.
- Undefined: speed is constant at STEP and the counter logic is absent.

Decomposition:
- Package bg_scroll_pkg holds:
  - direction bit-index localparams DIR_UP=3, DIR_DOWN=2, DIR_RIGHT=1, DIR_LEFT=0;
  - a wrap_add/wrap_sub function pair (value, step, modulus);
  - a typedef for the 10-bit coordinate.
- One natural sub-module, bg_frame_sync: 2-FF synchroniser plus rising-edge detector producing frame_tick.
- Offset update and address pipeline stay in the top module.

Test Plan:
- Reset, then 3 frame_clk pulses with direction=4'b0010 -> x_offset 1,2,3; y_offset 0; each frame_tick exactly 1 cycle wide.
- x_offset=0, direction=4'b0001, one frame -> x_offset=959. y_offset=719, direction=4'b0100 -> y_offset=0.
- direction=4'b1010 (up+right) from (5,5) -> (6,4). direction=4'b1100 -> y unchanged. collided=1 with 4'b0010 -> no change. recenter=1 with collided=1 -> (0,0).
- x_offset=900, y_offset=700, DrawX=100, DrawY=30, blank=1 -> 2 cycles later rom_address = 10*960+40 = 9640 and pix_blank=1. Same inputs with blank=0 -> rom_address=0, pix_blank=0.
- With BG_SCROLL_ACCEL_EN, STEP=1, STEP_MAX=4, ACCEL_FRAMES=8, right held for 40 frames -> speed steps 1→2→3→4 at frames 8/16/24 and stays 4. Release for 1 frame -> next move uses speed 1.
- Assert reset_n low mid-scroll with frame_clk held high -> all outputs 0 immediately. After release, no frame_tick until frame_clk goes low then high.
